// File: rtl/music_pkg.sv
// Shared definitions for the song playback path.
// Holds the sequencer state encoding, the bit layout of a note ROM word and
// the helper that turns the 4-bit duration field into duration units.
// No ports: imported by the sequencer top.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_NOTE  = 3'd3,
    ST_GAP   = 3'd4,
    ST_PAUSE = 3'd5
  } state_t;

  // Note ROM word: [11]=last, [10:4]=pitch, [3:0]=duration units
  localparam int ROM_W     = 12;
  localparam int LAST_BIT  = 11;
  localparam int PITCH_MSB = 10;
  localparam int PITCH_LSB = 4;
  localparam int DUR_MSB   = 3;
  localparam int PITCH_W   = PITCH_MSB - PITCH_LSB + 1;

  localparam logic [PITCH_W-1:0] REST_PITCH = 7'd0;
  localparam int DUR_ZERO_MEANS = 16;

  // A zero duration field encodes the longest note rather than an empty one.
  function automatic logic [4:0] dur_units(input logic [DUR_MSB:0] dur);
    if (dur == '0) return 5'(DUR_ZERO_MEANS);
    else           return {1'b0, dur};
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter used for note duration and articulation gap timing.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load count with load_val (takes priority over en)
//   load_val    cycle count to time out
//   en          count down this cycle; low holds the count (pause)
//   expire      high in the last enabled cycle of the loaded interval
// A value N loaded here produces exactly N enabled cycles before expire.
module note_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = en && (count == CNT_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// Playback controller between the song-select front end and the tone
// generator. Walks the note ROM of the selected song and times each note
// and the silent gap after it; supports pause/resume, song change while
// playing, and stop or loop at the end of the song.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   song_sel     debounced song index 0..2 (3 is ignored)
//   play_toggle  one-cycle press pulse: start / pause / resume
//   rom_addr     registered note ROM address {song, note_idx}
//   rom_data     ROM word, valid one cycle after rom_addr
//   pitch_out    pitch code for the tone generator
//   tone_en      tone generator enable
//   playing      high while fetching/playing a note or gap
//   done_pulse   one cycle when a non-looping song finishes
module song_sequencer
  import music_pkg::*;
#(
  parameter int TICK_DIV   = 3000000,
  parameter int GAP_CYCLES = 500000,
  parameter int ADDR_W     = 8,
  parameter int LOOP       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        song_sel,
  input  logic              play_toggle,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [6:0]        pitch_out,
  output logic              tone_en,
  output logic              playing,
  output logic              done_pulse
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DUR_W = $clog2(DUR_ZERO_MEANS * TICK_DIV + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [DUR_W-1:0] TICK_VAL = DUR_W'(TICK_DIV);
  localparam logic [GAP_W-1:0] GAP_VAL  = GAP_W'(GAP_CYCLES);

  state_t              state, state_nxt;
  state_t              resume_state, resume_nxt;
  logic [1:0]          cur_song, cur_song_nxt;
  logic [IDX_W-1:0]    note_idx, note_idx_nxt;
  logic [ADDR_W-1:0]   rom_addr_nxt;
  logic [PITCH_W-1:0]  pitch_nxt;
  logic                tone_nxt;
  logic                done_nxt;
  logic                last_q, last_nxt;

  logic                song_chg;
  logic                advance;
  logic                end_of_song;
  logic [PITCH_W-1:0]  rom_pitch;
  logic [DUR_MSB:0]    rom_dur;
  logic [DUR_W-1:0]    dur_load_val;
  logic                dur_load, dur_en, dur_expire;
  logic                gap_load, gap_en, gap_expire;

  assign rom_pitch    = rom_data[PITCH_MSB:PITCH_LSB];
  assign rom_dur      = rom_data[DUR_MSB:0];
  assign dur_load_val = DUR_W'(dur_units(rom_dur)) * TICK_VAL;

  // A different valid selection overrides everything else while active,
  // including a pause and a simultaneous toggle.
  assign song_chg = (state != ST_IDLE) && (song_sel != 2'd3) && (song_sel != cur_song);

  // Timers are frozen in the toggle cycle itself so the remaining count
  // survives a pause unchanged.
  assign dur_load = (state == ST_LOAD);
  assign dur_en   = (state == ST_NOTE) && !play_toggle && !song_chg;
  assign gap_load = dur_expire && (GAP_CYCLES > 0);
  assign gap_en   = (state == ST_GAP) && !play_toggle && !song_chg;

  assign end_of_song = last_q || (note_idx == {IDX_W{1'b1}});

  assign playing = (state == ST_FETCH) || (state == ST_LOAD) ||
                   (state == ST_NOTE)  || (state == ST_GAP);

  note_timer #(.CNT_W(DUR_W)) u_dur_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dur_load),
    .load_val (dur_load_val),
    .en       (dur_en),
    .expire   (dur_expire)
  );

  note_timer #(.CNT_W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_VAL),
    .en       (gap_en),
    .expire   (gap_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      resume_state <= ST_NOTE;
      cur_song     <= 2'd0;
      note_idx     <= '0;
      rom_addr     <= '0;
      pitch_out    <= '0;
      tone_en      <= 1'b0;
      done_pulse   <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      resume_state <= resume_nxt;
      cur_song     <= cur_song_nxt;
      note_idx     <= note_idx_nxt;
      rom_addr     <= rom_addr_nxt;
      pitch_out    <= pitch_nxt;
      tone_en      <= tone_nxt;
      done_pulse   <= done_nxt;
      last_q       <= last_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    resume_nxt   = resume_state;
    cur_song_nxt = cur_song;
    note_idx_nxt = note_idx;
    rom_addr_nxt = rom_addr;
    pitch_nxt    = pitch_out;
    tone_nxt     = tone_en;
    done_nxt     = 1'b0;
    last_nxt     = last_q;
    advance      = 1'b0;

    if (song_chg) begin
      cur_song_nxt = song_sel;
      note_idx_nxt = '0;
      rom_addr_nxt = {song_sel, {IDX_W{1'b0}}};
      tone_nxt     = 1'b0;
      state_nxt    = ST_FETCH;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play_toggle && (song_sel != 2'd3)) begin
            cur_song_nxt = song_sel;
            note_idx_nxt = '0;
            rom_addr_nxt = {song_sel, {IDX_W{1'b0}}};
            state_nxt    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_nxt = ST_LOAD;
        end
        ST_LOAD: begin
          pitch_nxt = rom_pitch;
          tone_nxt  = (rom_pitch != REST_PITCH);
          last_nxt  = rom_data[LAST_BIT];
          state_nxt = ST_NOTE;
        end
        ST_NOTE: begin
          if (play_toggle) begin
            resume_nxt = ST_NOTE;
            tone_nxt   = 1'b0;
            state_nxt  = ST_PAUSE;
          end else if (dur_expire) begin
            tone_nxt = 1'b0;
            if (GAP_CYCLES > 0) state_nxt = ST_GAP;
            else                advance   = 1'b1;
          end
        end
        ST_GAP: begin
          if (play_toggle) begin
            resume_nxt = ST_GAP;
            state_nxt  = ST_PAUSE;
          end else if (gap_expire) begin
            advance = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (play_toggle) begin
            state_nxt = resume_state;
            tone_nxt  = (resume_state == ST_NOTE) && (pitch_out != REST_PITCH);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase

      if (advance) begin
        if (end_of_song) begin
          if (LOOP != 0) begin
            note_idx_nxt = '0;
            rom_addr_nxt = {cur_song, {IDX_W{1'b0}}};
            state_nxt    = ST_FETCH;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          note_idx_nxt = note_idx + IDX_W'(1);
          rom_addr_nxt = {cur_song, note_idx + IDX_W'(1)};
          state_nxt    = ST_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with TICK_DIV=4, GAP_CYCLES=2, ADDR_W=8.
// A LOOP=0 instance is compared every cycle against a timeline model that
// expands the selected song into per-cycle fetch/load/note/gap entries;
// a LOOP=1 instance is checked with literal expectations.
module tb_song_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 2;

  localparam logic [1:0] K_F = 2'd0, K_L = 2'd1, K_N = 2'd2, K_G = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [6:0] pitch;
    logic [7:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        tog = 1'b0;
  logic [7:0]  rom_addr;
  logic [11:0] rom_q;
  logic [6:0]  pitch_out;
  logic        tone_en, playing, done_pulse;

  logic [1:0]  lsel = 2'd0;
  logic        ltog = 1'b0;
  logic [7:0]  l_rom_addr;
  logic [11:0] l_rom_q;
  logic [6:0]  l_pitch;
  logic        l_tone, l_play, l_done;

  logic [11:0] rom [0:255];

  int n_checks = 0;
  int n_fail   = 0;
  int ldone_cnt = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q   <= rom[rom_addr];
    l_rom_q <= rom[l_rom_addr];
  end

  song_sequencer #(.TICK_DIV(TICK), .GAP_CYCLES(GAP), .ADDR_W(8), .LOOP(0)) dut (
    .clk(clk), .rst_n(rst_n), .song_sel(sel), .play_toggle(tog),
    .rom_addr(rom_addr), .rom_data(rom_q), .pitch_out(pitch_out),
    .tone_en(tone_en), .playing(playing), .done_pulse(done_pulse)
  );

  song_sequencer #(.TICK_DIV(TICK), .GAP_CYCLES(GAP), .ADDR_W(8), .LOOP(1)) dut_loop (
    .clk(clk), .rst_n(rst_n), .song_sel(lsel), .play_toggle(ltog),
    .rom_addr(l_rom_addr), .rom_data(l_rom_q), .pitch_out(l_pitch),
    .tone_en(l_tone), .playing(l_play), .done_pulse(l_done)
  );

  // ---------------- timeline model ----------------
  ent_t       tl[$];
  ent_t       cur = '0;
  bit         m_active = 0, m_paused = 0, m_done = 0;
  logic [1:0] m_song = 2'd0;
  logic [6:0] m_pitch = 7'd0;
  logic [7:0] m_addr = 8'd0;

  function automatic void build(input logic [1:0] s);
    ent_t e;
    logic [11:0] w;
    int d;
    tl.delete();
    for (int i = 0; i < 64; i++) begin
      e.addr  = {s, 6'(i)};
      w       = rom[e.addr];
      e.pitch = w[10:4];
      d       = (w[3:0] == 4'd0) ? 16 : int'(w[3:0]);
      e.kind = K_F; tl.push_back(e);
      e.kind = K_L; tl.push_back(e);
      e.kind = K_N;
      for (int k = 0; k < d * TICK; k++) tl.push_back(e);
      e.kind = K_G;
      for (int k = 0; k < GAP; k++) tl.push_back(e);
      if (w[11]) break;
    end
  endfunction

  function automatic void start_next();
    cur    = tl.pop_front();
    m_addr = cur.addr;
    if (cur.kind == K_N) m_pitch = cur.pitch;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_paused = 0; m_done = 0;
      m_song = 2'd0; m_pitch = 7'd0; m_addr = 8'd0;
      tl.delete();
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (tog && sel != 2'd3) begin
          m_song = sel; build(sel); start_next(); m_active = 1;
        end
      end else if (sel != 2'd3 && sel != m_song) begin
        m_song = sel; build(sel); m_paused = 0; start_next();
      end else if (m_paused) begin
        if (tog) m_paused = 0;
      end else if (tog && (cur.kind == K_N || cur.kind == K_G)) begin
        m_paused = 1;
      end else if (tl.size() == 0) begin
        m_active = 0; m_done = 1;
      end else begin
        start_next();
      end
    end
  end

  logic e_tone, e_play;
  assign e_tone = m_active && !m_paused && cur.kind == K_N && cur.pitch != 7'd0;
  assign e_play = m_active && !m_paused;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model.tone_en",    32'(tone_en),    32'(e_tone));
      check("model.playing",    32'(playing),    32'(e_play));
      check("model.pitch_out",  32'(pitch_out),  32'(m_pitch));
      check("model.rom_addr",   32'(rom_addr),   32'(m_addr));
      check("model.done_pulse", 32'(done_pulse), 32'(m_done));
    end
  end

  always @(negedge clk) if (l_done) ldone_cnt++;

  // ---------------- capture helpers ----------------
  logic       w_tone [0:127];
  logic       w_play [0:127];
  logic       w_done [0:127];
  logic [6:0] w_pitch[0:127];
  logic [7:0] w_addr [0:127];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w_tone[i] = tone_en; w_play[i] = playing; w_done[i] = done_pulse;
      w_pitch[i] = pitch_out; w_addr[i] = rom_addr;
    end
  endtask

  task automatic lcapture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w_tone[i] = l_tone; w_addr[i] = l_rom_addr;
    end
  endtask

  function automatic int cnt_tone(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (w_tone[i]) c++;
    return c;
  endfunction

  function automatic int cnt_play(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (w_play[i]) c++;
    return c;
  endfunction

  function automatic int first_idx_tone(input int n);
    for (int i = 0; i < n; i++) if (w_tone[i]) return i;
    return -1;
  endfunction

  function automatic int first_idx_done(input int n);
    for (int i = 0; i < n; i++) if (w_done[i]) return i;
    return -1;
  endfunction

  function automatic int cnt_done(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (w_done[i]) c++;
    return c;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    tog = 1'b1;
    step(1);
    tog = 1'b0;
  endtask

  function automatic logic [11:0] mk(input bit last, input int pitch, input int dur);
    return {last, 7'(pitch), 4'(dur)};
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(1, 0, 1);
    rom[8'h00] = mk(0, 5, 2);  rom[8'h01] = mk(0, 6, 2);  rom[8'h02] = mk(1, 7, 2);
    rom[8'h40] = mk(0, 10, 2); rom[8'h41] = mk(1, 20, 1);
    rom[8'h80] = mk(0, 30, 1); rom[8'h81] = mk(0, 0, 3);  rom[8'h82] = mk(1, 40, 0);

    step(3);
    check("reset.rom_addr",   32'(rom_addr),   32'h0);
    check("reset.tone_en",    32'(tone_en),    32'h0);
    check("reset.playing",    32'(playing),    32'h0);
    check("reset.done_pulse", 32'(done_pulse), 32'h0);
    check("reset.pitch_out",  32'(pitch_out),  32'h0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    step(2);

    // Looping instance: song 1 wraps back to 0x40 after the last gap.
    lsel = 2'd1;
    step(1);
    ltog = 1'b1; step(1); ltog = 1'b0;
    lcapture(40);
    check("loop.addr_first",  32'(w_addr[0]),  32'h40);
    check("loop.addr_second", 32'(w_addr[19]), 32'h41);
    check("loop.addr_wrap",   32'(w_addr[20]), 32'h40);
    check("loop.tone_again",  32'(cnt_tone(22, 29)), 32'd8);

    // Two-note song 1.
    sel = 2'd1;
    step(2);
    pulse();
    capture(24);
    check("song1.addr0",       32'(w_addr[0]),  32'h40);
    check("song1.first_tone",  32'(first_idx_tone(24)), 32'd2);
    check("song1.note0_len",   32'(cnt_tone(2, 9)),     32'd8);
    check("song1.pitch0",      32'(w_pitch[2]),  32'd10);
    check("song1.quiet",       32'(cnt_tone(10, 13)),   32'd0);
    check("song1.addr1",       32'(w_addr[12]), 32'h41);
    check("song1.note1_len",   32'(cnt_tone(14, 17)),   32'd4);
    check("song1.pitch1",      32'(w_pitch[14]), 32'd20);
    check("song1.done_at",     32'(first_idx_done(24)), 32'd20);
    check("song1.done_count",  32'(cnt_done(24)),       32'd1);
    check("song1.idle_play",   32'(w_play[20]), 32'd0);

    // Song 2: short note, rest, dur=0 note.
    sel = 2'd2;
    step(2);
    pulse();
    capture(100);
    check("song2.rest_quiet",  32'(cnt_tone(10, 23)), 32'd0);
    check("song2.play_high",   32'(cnt_play(0, 91)),  32'd92);
    check("song2.dur0_len",    32'(cnt_tone(26, 89)), 32'd64);
    check("song2.dur0_pitch",  32'(w_pitch[26]),      32'd40);
    check("song2.gap_quiet",   32'(cnt_tone(90, 91)), 32'd0);
    check("song2.done_at",     32'(first_idx_done(100)), 32'd92);

    // Pause in the 4th cycle of an 8-cycle note, hold, resume.
    sel = 2'd1;
    step(2);
    pulse();
    step(5);
    pulse();
    check("pause.tone_off", 32'(tone_en), 32'd0);
    check("pause.playing",  32'(playing), 32'd0);
    step(19);
    pulse();
    capture(8);
    check("pause.resume_len", 32'(cnt_tone(0, 4)), 32'd5);
    check("pause.resume_end", 32'(w_tone[5]),      32'd0);
    step(25);

    // Song change mid-note, toggle during FETCH ignored, song_sel=3 ignored.
    sel = 2'd0;
    step(2);
    pulse();
    step(5);
    sel = 2'd2;
    step(1);
    check("chg.tone_drop", 32'(tone_en),  32'd0);
    check("chg.addr",      32'(rom_addr), 32'h80);
    pulse();
    step(1);
    check("chg.new_tone",  32'(tone_en),   32'd1);
    check("chg.new_pitch", 32'(pitch_out), 32'd30);
    sel = 2'd3;
    step(3);
    check("chg.sel3_play", 32'(playing),  32'd1);
    check("chg.sel3_addr", 32'(rom_addr), 32'h80);
    step(100);

    // Song change and toggle together: new song plays, not paused.
    sel = 2'd1;
    step(2);
    pulse();
    step(4);
    sel = 2'd0;
    tog = 1'b1;
    step(1);
    tog = 1'b0;
    check("both.playing", 32'(playing),  32'd1);
    check("both.addr",    32'(rom_addr), 32'h00);
    step(2);
    check("both.tone",    32'(tone_en),   32'd1);
    check("both.pitch",   32'(pitch_out), 32'd5);
    step(45);

    // Asynchronous reset in the middle of a note.
    sel = 2'd1;
    step(2);
    pulse();
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.tone_en",   32'(tone_en),  32'd0);
    check("arst.playing",   32'(playing),  32'd0);
    check("arst.rom_addr",  32'(rom_addr), 32'h0);
    check("arst.loop_play", 32'(l_play),   32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);

    check("loop.no_done", 32'(ldone_cnt), 32'd0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
